// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkgate_pkg.sv
// ============================================================================
// Module  : gf180mcu_fd_sc_mcu9t5v0__clkgate_pkg
// Brief   : Shared types and defaults for the clock-gate controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package gf180mcu_fd_sc_mcu9t5v0__clkgate_pkg;

  // Controller states. OFF is all-zero so a cleared state register means
  // "clock gated".
  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_IDLE = 2'd3
  } cg_state_t;

  localparam int WAKE_CYCLES_DEFAULT = 2;
  localparam int IDLE_W_DEFAULT      = 8;

endpackage

`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkgate_cnt.sv
// ============================================================================
// Module  : gf180mcu_fd_sc_mcu9t5v0__clkgate_cnt
// Brief   : Loadable down-counter with zero/one flags, shared by the wake
//           settling delay and the idle hold-off.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gf180mcu_fd_sc_mcu9t5v0__clkgate_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         is_zero,
  output logic         is_one
);

  logic [W-1:0] count;

  // Load has priority; decrement saturates at zero so the count never wraps.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign is_zero = (count == '0);
  assign is_one  = (count == W'(1));

endmodule

`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkgate_ctrl.sv
// ============================================================================
// Module  : gf180mcu_fd_sc_mcu9t5v0__clkgate_ctrl
// Brief   : Enable controller for a latch-based ICG. Wakes the local clock on
//           request with a settling delay, acknowledges once stable, and
//           gates the clock off after an idle hold-off.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gf180mcu_fd_sc_mcu9t5v0__clkgate_ctrl
  import gf180mcu_fd_sc_mcu9t5v0__clkgate_pkg::*;
#(
  parameter int WAKE_CYCLES = WAKE_CYCLES_DEFAULT,
  parameter int IDLE_W      = IDLE_W_DEFAULT
) (
  input  logic              CLK,
  input  logic              RN,
  input  logic              REQ,
  input  logic              BUSY,
  input  logic              TE,
  input  logic [IDLE_W-1:0] IDLE_LIM,
  output logic              E,
  output logic              ACK,
  output logic              GATED
);

  // The counter reaches zero after WAKE_CYCLES-1 decrements, so ON is
  // entered exactly WAKE_CYCLES edges after leaving OFF.
  localparam logic [IDLE_W-1:0] WAKE_LOAD = IDLE_W'(WAKE_CYCLES - 1);

  cg_state_t         state;
  cg_state_t         nxt;
  logic              active;
  logic              cnt_load;
  logic [IDLE_W-1:0] cnt_val;
  logic              cnt_dec;
  logic              cnt_zero;
  logic              cnt_one;

  assign active = REQ | BUSY | TE;

  gf180mcu_fd_sc_mcu9t5v0__clkgate_cnt #(
    .W (IDLE_W)
  ) u_cnt (
    .clk      (CLK),
    .clr_n    (RN),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .is_zero  (cnt_zero),
    .is_one   (cnt_one)
  );

  // Next-state and counter control; a pending request in IDLE beats expiry.
  always_comb begin
    nxt      = state;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    case (state)
      ST_OFF: begin
        if (active) begin
          nxt      = ST_WAKE;
          cnt_load = 1'b1;
          cnt_val  = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        if (cnt_zero) nxt = ST_ON;
        else          cnt_dec = 1'b1;
      end
      ST_ON: begin
        if (!active) begin
          if (IDLE_LIM == '0) begin
            nxt = ST_OFF;
          end else begin
            nxt      = ST_IDLE;
            cnt_load = 1'b1;
            cnt_val  = IDLE_LIM;
          end
        end
      end
      ST_IDLE: begin
        if (active)       nxt = ST_ON;
        else if (cnt_one) nxt = ST_OFF;
        else              cnt_dec = 1'b1;
      end
      default: nxt = ST_OFF;
    endcase
  end

  // State and outputs registered together so E/ACK/GATED come straight off flops.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state <= ST_OFF;
      E     <= 1'b0;
      ACK   <= 1'b0;
      GATED <= 1'b1;
    end else begin
      state <= nxt;
      E     <= (nxt != ST_OFF);
      ACK   <= (nxt == ST_ON);
      GATED <= (nxt == ST_OFF);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__clkgate_ctrl.sv
// ============================================================================
// Module  : tb_gf180mcu_fd_sc_mcu9t5v0__clkgate_ctrl
// Brief   : Self-checking bench for the clock-gate controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gf180mcu_fd_sc_mcu9t5v0__clkgate_ctrl;

  localparam int WAKE_CYCLES = 2;
  localparam int IDLE_W      = 8;

  logic              CLK = 1'b0;
  logic              RN;
  logic              REQ;
  logic              BUSY;
  logic              TE;
  logic [IDLE_W-1:0] IDLE_LIM;
  logic              E;
  logic              ACK;
  logic              GATED;

  int pass_cnt  = 0;
  int total_cnt = 0;

  gf180mcu_fd_sc_mcu9t5v0__clkgate_ctrl #(
    .WAKE_CYCLES (WAKE_CYCLES),
    .IDLE_W      (IDLE_W)
  ) dut (
    .CLK      (CLK),
    .RN       (RN),
    .REQ      (REQ),
    .BUSY     (BUSY),
    .TE       (TE),
    .IDLE_LIM (IDLE_LIM),
    .E        (E),
    .ACK      (ACK),
    .GATED    (GATED)
  );

  always #5 CLK = ~CLK;

  // Reference model: the clock is either stopped, settling (wake_left edges
  // until usable), usable, or counting idle_left edges down before stopping.
  logic m_e   = 1'b0;
  logic m_ack = 1'b0;
  int   wake_left = 0;
  int   idle_left = 0;
  wire  m_act = REQ | BUSY | TE;

  always @(posedge CLK or negedge RN) begin
    if (!RN) begin
      m_e       <= 1'b0;
      m_ack     <= 1'b0;
      wake_left <= 0;
      idle_left <= 0;
    end else if (!m_e) begin
      if (m_act) begin
        m_e       <= 1'b1;
        wake_left <= WAKE_CYCLES;
      end
    end else if (wake_left > 0) begin
      wake_left <= wake_left - 1;
      if (wake_left == 1) m_ack <= 1'b1;
    end else if (m_ack) begin
      if (!m_act) begin
        m_ack <= 1'b0;
        if (IDLE_LIM == 0) m_e <= 1'b0;
        else               idle_left <= int'(IDLE_LIM);
      end
    end else begin
      if (m_act) begin
        m_ack <= 1'b1;
      end else begin
        idle_left <= idle_left - 1;
        if (idle_left == 1) m_e <= 1'b0;
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge CLK) begin
    total_cnt++;
    if ({E, ACK, GATED} === {m_e, m_ack, ~m_e}) pass_cnt++;
    else $display("FAIL cycle_cmp t=%0t E/ACK/GATED got=%b%b%b want=%b%b%b",
                  $time, E, ACK, GATED, m_e, m_ack, ~m_e);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Hand-computed expectations, applied to both the DUT and the model.
  task automatic pin(input string name, input logic exp_e, input logic exp_ack);
    total_cnt++;
    if ({E, ACK, GATED} === {exp_e, exp_ack, ~exp_e}) pass_cnt++;
    else $display("FAIL %s dut E/ACK/GATED got=%b%b%b want=%b%b%b",
                  name, E, ACK, GATED, exp_e, exp_ack, ~exp_e);
    total_cnt++;
    if ({m_e, m_ack} === {exp_e, exp_ack}) pass_cnt++;
    else $display("FAIL %s model E/ACK got=%b%b want=%b%b",
                  name, m_e, m_ack, exp_e, exp_ack);
  endtask

  initial begin
    logic [63:0] pr;
    logic [63:0] pb;
    logic [63:0] pt;
    pr = 64'h0F00_3C00_00F0_8001;
    pb = 64'h0000_0300_0C00_0060;
    pt = 64'h00E0_0000_0000_0800;

    RN = 1'b0; REQ = 1'b0; BUSY = 1'b0; TE = 1'b0; IDLE_LIM = 8'd4;
    tick(2);
    pin("reset", 1'b0, 1'b0);

    // Basic wake: E after 1 edge, ACK after WAKE_CYCLES edges.
    RN = 1'b1; REQ = 1'b1;
    tick(1); pin("wake_e", 1'b1, 1'b0);
    tick(1); pin("wake_mid", 1'b1, 1'b0);
    tick(1); pin("wake_ack", 1'b1, 1'b1);

    // Idle hold-off of 4 edges.
    REQ = 1'b0; IDLE_LIM = 8'd4;
    tick(1); pin("idle_enter", 1'b1, 1'b0);
    tick(3); pin("idle_hold", 1'b1, 1'b0);
    tick(1); pin("idle_off", 1'b0, 1'b0);

    // Request arriving on the expiry edge wins.
    REQ = 1'b1;
    tick(3); pin("rewake_ack", 1'b1, 1'b1);
    REQ = 1'b0; IDLE_LIM = 8'd3;
    tick(3); pin("pre_expiry", 1'b1, 1'b0);
    REQ = 1'b1;
    tick(1); pin("collide", 1'b1, 1'b1);

    // Zero hold-off goes straight to OFF.
    REQ = 1'b0; IDLE_LIM = 8'd0;
    tick(1); pin("lim0_off", 1'b0, 1'b0);

    // Asynchronous reset in the middle of WAKE.
    REQ = 1'b1;
    tick(1);
    #2 RN = 1'b0;
    #1 pin("async_rst", 1'b0, 1'b0);
    tick(2);
    RN = 1'b1;
    tick(1); pin("rst_wake_e", 1'b1, 1'b0);
    tick(1); pin("rst_wake_mid", 1'b1, 1'b0);
    tick(1); pin("rst_wake_ack", 1'b1, 1'b1);
    REQ = 1'b0; IDLE_LIM = 8'd2;
    tick(3); pin("rst_idle_off", 1'b0, 1'b0);

    // Test enable forces the clock on indefinitely.
    TE = 1'b1;
    tick(3); pin("te_ack", 1'b1, 1'b1);
    tick(20); pin("te_hold", 1'b1, 1'b1);
    TE = 1'b0;
    tick(1); pin("te_idle", 1'b1, 1'b0);
    tick(1); pin("te_idle2", 1'b1, 1'b0);
    tick(1); pin("te_off", 1'b0, 1'b0);

    // REQ dropped during WAKE still reaches ON; BUSY re-wakes from IDLE.
    REQ = 1'b1;
    tick(1);
    REQ = 1'b0;
    tick(2); pin("nonabort_ack", 1'b1, 1'b1);
    IDLE_LIM = 8'd2;
    tick(1); pin("nonabort_idle", 1'b1, 1'b0);
    BUSY = 1'b1;
    tick(1); pin("busy_rewake", 1'b1, 1'b1);

    // IDLE_LIM changed mid-IDLE does not affect the running countdown.
    IDLE_LIM = 8'd5; BUSY = 1'b0;
    tick(1);
    IDLE_LIM = 8'd1;
    tick(4); pin("lim_latched", 1'b1, 1'b0);
    tick(1); pin("lim_off", 1'b0, 1'b0);

    // Mixed directed pattern, checked every cycle by the model.
    for (int i = 0; i < 64; i++) begin
      REQ      = pr[i];
      BUSY     = pb[i];
      TE       = pt[i];
      IDLE_LIM = IDLE_W'(i % 4);
      tick(1);
    end
    REQ = 1'b0; BUSY = 1'b0; TE = 1'b0;
    tick(8);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
